// File: rtl/hams_merge_sort_kway_merge_pkg.sv
`default_nettype none
// ============================================================================
// hams_pkg : shared types and constants for the k-way merge consumer
// Revision : 1.0
// ============================================================================
package hams_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MERGE   = 2'd1,
        RUN_END = 2'd2
    } merge_state_e;

    localparam int HAMS_MERGE_MIN_DEPTH = 4;

endpackage
`default_nettype wire

// File: rtl/hams_merge_lane_fifo.sv
`default_nettype none
// ============================================================================
// hams_merge_lane_fifo : per-lane FIFO with first-word-fall-through head
// Revision : 1.0
// ============================================================================
module hams_merge_lane_fifo #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic [DATA_WIDTH-1:0]   head_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [AW:0]           count_q;
    logic                  push_en;
    logic                  pop_en;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full lane is dropped here; the top reports it as overflow.
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/hams_merge_sort_kway_merge.sv
`default_nettype none
// ============================================================================
// hams_merge_sort_kway_merge : NUM_MEM-way merge of sorted lane runs
// Revision : 1.0
// ============================================================================
module hams_merge_sort_kway_merge
    import hams_pkg::*;
#(
    parameter int NUM_MEM    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LANE_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          pause,
    input  logic [ADDR_WIDTH:0]           run_len,
    input  logic                          in_push,
    input  logic [NUM_MEM*DATA_WIDTH-1:0] in_data,
    output logic                          in_full,
    input  logic                          out_full,
    output logic                          out_push,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          run_done,
    output logic                          busy,
    output logic                          overflow
);

    localparam int DEPTH = (LANE_DEPTH < HAMS_MERGE_MIN_DEPTH) ? HAMS_MERGE_MIN_DEPTH : LANE_DEPTH;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int IW    = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1;
    localparam int RW    = ADDR_WIDTH + 1;

    merge_state_e          state_q;
    merge_state_e          state_d;
    logic [RW-1:0]         run_len_q;
    logic [RW-1:0]         cons_q [NUM_MEM];
    logic [RW-1:0]         cons_d [NUM_MEM];
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  overflow_q;

    logic [NUM_MEM-1:0]    lane_push;
    logic [NUM_MEM-1:0]    lane_pop;
    logic [NUM_MEM-1:0]    lane_full;
    logic [NUM_MEM-1:0]    lane_empty;
    logic [NUM_MEM-1:0]    lane_exh;
    logic [NUM_MEM-1:0]    lane_hi;
    logic [DATA_WIDTH-1:0] lane_head [NUM_MEM];
    logic [CW-1:0]         lane_count [NUM_MEM];

    logic                  push_ok;
    logic                  sel_ready;
    logic                  any_live;
    logic                  sel_fire;
    logic                  all_done;
    logic [IW-1:0]         win_idx;
    logic [DATA_WIDTH-1:0] win_data;

    // Lanes take words in MERGE and RUN_END so the next run can prefetch.
    assign push_ok = in_push && !pause && !start && (state_q != IDLE);

    for (genvar g = 0; g < NUM_MEM; g++) begin : g_lane
        assign lane_push[g] = push_ok;
        assign lane_pop[g]  = sel_fire && (win_idx == IW'(g));
        assign lane_exh[g]  = (cons_q[g] == run_len_q);
        assign lane_hi[g]   = (lane_count[g] >= CW'(DEPTH - 2));

        hams_merge_lane_fifo #(
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane_fifo (
            .clk     (clk),
            .rst     (rst),
            .clr_i   (start),
            .push_i  (lane_push[g]),
            .pop_i   (lane_pop[g]),
            .data_i  (in_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .head_o  (lane_head[g]),
            .count_o (lane_count[g]),
            .full_o  (lane_full[g]),
            .empty_o (lane_empty[g])
        );
    end

    // Ascending scan with strict less-than keeps ties on the lowest lane.
    always_comb begin
        sel_ready = 1'b1;
        any_live  = 1'b0;
        win_idx   = '0;
        win_data  = '0;
        for (int i = 0; i < NUM_MEM; i++) begin
            if (!lane_exh[i]) begin
                if (lane_empty[i]) begin
                    sel_ready = 1'b0;
                end
                if (!any_live || (lane_head[i] < win_data)) begin
                    win_idx  = IW'(i);
                    win_data = lane_head[i];
                end
                any_live = 1'b1;
            end
        end
    end

    assign sel_fire = (state_q == MERGE) && !pause && !out_full && !start
                      && sel_ready && any_live;

    always_comb begin
        all_done = 1'b1;
        for (int i = 0; i < NUM_MEM; i++) begin
            cons_d[i] = cons_q[i] + {{(RW-1){1'b0}}, lane_pop[i]};
            if (cons_d[i] != run_len_q) begin
                all_done = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = MERGE;
        end else if (!pause) begin
            case (state_q)
                MERGE:   if (all_done) state_d = RUN_END;
                RUN_END: state_d = MERGE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_len_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < NUM_MEM; i++) begin
                cons_q[i] <= '0;
            end
        end else if (start) begin
            run_len_q   <= run_len;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < NUM_MEM; i++) begin
                cons_q[i] <= '0;
            end
        end else if (!pause) begin
            out_valid_q <= sel_fire;
            if (sel_fire) begin
                out_data_q <= win_data;
            end
            if (|(lane_push & lane_full)) begin
                overflow_q <= 1'b1;
            end
            for (int i = 0; i < NUM_MEM; i++) begin
                cons_q[i] <= (state_q == RUN_END) ? '0 : cons_d[i];
            end
        end
    end

    assign out_push = out_valid_q && !pause;
    assign out_data = out_data_q;
    assign run_done = (state_q == RUN_END);
    assign busy     = (state_q != IDLE);
    assign overflow = overflow_q;
    assign in_full  = |lane_hi;

endmodule
`default_nettype wire

// File: tb/tb_hams_merge_sort_kway_merge.sv
`default_nettype none
// ============================================================================
// tb_hams_merge_sort_kway_merge : scoreboard bench for the k-way merge
// Revision : 1.0
// ============================================================================
module tb_hams_merge_sort_kway_merge;

    localparam int NM = 4;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int LD = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              pause;
    logic [AW:0]       run_len;
    logic              in_push;
    logic [NM*DW-1:0]  in_data;
    logic              in_full;
    logic              out_full;
    logic              out_push;
    logic [DW-1:0]     out_data;
    logic              run_done;
    logic              busy;
    logic              overflow;

    always #5 clk = ~clk;

    hams_merge_sort_kway_merge #(
        .NUM_MEM    (NM),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LANE_DEPTH (LD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pause    (pause),
        .run_len  (run_len),
        .in_push  (in_push),
        .in_data  (in_data),
        .in_full  (in_full),
        .out_full (out_full),
        .out_push (out_push),
        .out_data (out_data),
        .run_done (run_done),
        .busy     (busy),
        .overflow (overflow)
    );

    typedef struct {
        logic [DW-1:0] data;
        bit            last;
    } exp_t;

    exp_t              exp_q[$];
    int unsigned       run_vals[$];
    logic [NM*DW-1:0]  vecs[$];
    int                n_checks = 0;
    int                n_fail = 0;
    int                out_cnt = 0;
    int                cyc = 0;
    int                first_out_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every presented word is checked against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_push) begin
                out_cnt++;
                if (first_out_cyc < 0) first_out_cyc = cyc;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out: got data %0d, required no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data) begin
                        n_fail++;
                        $display("FAIL out_data: got %0d, required %0d", out_data, e.data);
                    end
                    n_checks++;
                    if (run_done !== e.last) begin
                        n_fail++;
                        $display("FAIL run_done_with_word: got %0b, required %0b", run_done, e.last);
                    end
                end
            end else if (!pause) begin
                n_checks++;
                if (run_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL spurious_run_done: got %0b, required 0", run_done);
                end
            end
        end
    end

    task automatic check(input string name, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NM*DW-1:0] mk(input int unsigned a, input int unsigned b,
                                             input int unsigned c, input int unsigned d);
        return {d[DW-1:0], c[DW-1:0], b[DW-1:0], a[DW-1:0]};
    endfunction

    // Reference model: a run's merged output is the ascending sort of every word in it.
    task automatic expect_run();
        logic [NM*DW-1:0] v;
        exp_t e;
        run_vals.delete();
        foreach (vecs[j]) begin
            v = vecs[j];
            for (int l = 0; l < NM; l++) run_vals.push_back(v[l*DW +: DW]);
        end
        run_vals.sort();
        foreach (run_vals[i]) begin
            e.data = run_vals[i];
            e.last = (i == run_vals.size() - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_start(input int rl);
        start   = 1'b1;
        run_len = (AW+1)'(rl);
        tick();
        start   = 1'b0;
    endtask

    task automatic push_one(input logic [NM*DW-1:0] v);
        in_data = v;
        in_push = 1'b1;
        tick();
        in_push = 1'b0;
    endtask

    task automatic push_all(input bit noisy);
        bit sent;
        int k;
        foreach (vecs[j]) begin
            sent = 1'b0;
            k = 0;
            while (!sent) begin
                out_full = noisy && ($urandom_range(0, 3) == 0);
                pause    = noisy && (k < 20) && ($urandom_range(0, 4) == 0);
                if (!pause) begin
                    push_one(vecs[j]);
                    sent = 1'b1;
                end else begin
                    tick();
                    k++;
                end
            end
        end
    endtask

    task automatic drain(input string name, input bit noisy);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            out_full = noisy && ($urandom_range(0, 3) == 0);
            pause    = noisy && ($urandom_range(0, 6) == 0);
            tick();
            k++;
        end
        out_full = 1'b0;
        pause    = 1'b0;
        check(name, exp_q.size(), 0);
        tick();
        tick();
    endtask

    task automatic gen_run(input int rl);
        int unsigned lane_q[$];
        logic [NM*DW-1:0] v;
        vecs.delete();
        for (int j = 0; j < rl; j++) vecs.push_back('0);
        for (int l = 0; l < NM; l++) begin
            lane_q.delete();
            for (int j = 0; j < rl; j++)
                lane_q.push_back(($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 7));
            lane_q.sort();
            for (int j = 0; j < rl; j++) begin
                v = vecs[j];
                v[l*DW +: DW] = lane_q[j];
                vecs[j] = v;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        int push_cyc;
        int k;
        int rl;

        rst = 1'b1; start = 1'b0; pause = 1'b0; in_push = 1'b0;
        out_full = 1'b0; run_len = '0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_push", out_push, 0);
        check("rst_out_data", out_data, 0);
        check("rst_run_done", run_done, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_in_full", in_full, 0);
        rst = 1'b0;
        tick();

        // Basic two-word merge with first-output latency.
        do_start(2);
        check("busy_after_start", busy, 1);
        vecs.delete();
        vecs.push_back(mk(5, 1, 7, 3));
        vecs.push_back(mk(6, 2, 8, 4));
        expect_run();
        first_out_cyc = -1;
        push_cyc = cyc;
        push_all(1'b0);
        drain("basic_drain", 1'b0);
        check("first_latency", first_out_cyc - push_cyc, 2);

        // All-equal keys.
        do_start(1);
        vecs.delete();
        vecs.push_back(mk(9, 9, 9, 9));
        expect_run();
        push_all(1'b0);
        drain("tie_drain", 1'b0);

        // Lane 2 runs dry before its second word arrives.
        do_start(2);
        vecs.delete();
        vecs.push_back(mk(10, 10, 1, 10));
        vecs.push_back(mk(11, 11, 2, 11));
        expect_run();
        push_one(vecs[0]);
        s = out_cnt;
        repeat (4) tick();
        check("stall_window_outputs", out_cnt - s, 1);
        push_one(vecs[1]);
        drain("stall_drain", 1'b0);

        // out_full and pause in the middle of a run.
        do_start(4);
        gen_run(4);
        expect_run();
        push_all(1'b0);
        tick();
        out_full = 1'b1;
        s = out_cnt;
        repeat (4) tick();
        check("out_full_window_le1", (out_cnt - s) <= 1, 1);
        out_full = 1'b0;
        tick();
        pause = 1'b1;
        s = out_cnt;
        repeat (3) tick();
        check("pause_window_outputs", out_cnt - s, 0);
        check("pause_out_push_low", out_push, 0);
        pause = 1'b0;
        drain("bp_drain", 1'b0);

        // Lane fill: in_full threshold and overflow stickiness.
        do_start(8);
        out_full = 1'b1;
        push_one(mk(1, 1, 1, 1));
        check("in_full_after_1", in_full, 0);
        push_one(mk(2, 2, 2, 2));
        check("in_full_after_2", in_full, 1);
        push_one(mk(3, 3, 3, 3));
        push_one(mk(4, 4, 4, 4));
        check("overflow_at_full", overflow, 0);
        push_one(mk(5, 5, 5, 5));
        check("overflow_set", overflow, 1);
        repeat (3) tick();
        check("overflow_sticky", overflow, 1);
        do_start(1);
        check("overflow_cleared_by_start", overflow, 0);
        check("in_full_cleared_by_start", in_full, 0);
        out_full = 1'b0;
        tick();

        // Reset in the middle of a run.
        do_start(2);
        vecs.delete();
        vecs.push_back(mk(5, 1, 7, 3));
        vecs.push_back(mk(6, 2, 8, 4));
        expect_run();
        s = out_cnt;
        push_all(1'b0);
        k = 0;
        while ((out_cnt - s) < 3 && k < 50) begin
            tick();
            k++;
        end
        check("rst_mid_words_seen", out_cnt - s, 3);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_push", out_push, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_run_done", run_done, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_full", in_full, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        do_start(1);
        vecs.delete();
        vecs.push_back(mk(4, 3, 2, 1));
        expect_run();
        push_all(1'b0);
        drain("post_rst_drain", 1'b0);

        // Randomized runs, several back-to-back runs per start, with noise.
        for (int t = 0; t < 10; t++) begin
            rl = $urandom_range(1, 4);
            do_start(rl);
            for (int r = 0; r < int'($urandom_range(1, 3)); r++) begin
                gen_run(rl);
                expect_run();
                push_all(1'b1);
                drain("rand_drain", 1'b1);
            end
        end

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hams_merge_sort_kway_merge.md
# hams_merge_sort_kway_merge

Consumer on the read side of the merge-sort column-queue path. Accepts one word per memory lane per push (NUM_MEM sorted runs of `run_len` words each), buffers each lane in a small lane FIFO, and emits the NUM_MEM-way merged ascending stream into the write-back queue. Its `in_full` is the back-pressure the column-queue controller samples as `fifo_full`; its output feeds the queue the controller pops during write-back.

## Interface
- NUM_MEM, 4, number of lanes / sorted runs merged per pass
- DATA_WIDTH, 32, unsigned key width
- ADDR_WIDTH, 10, memory address width; run length is ADDR_WIDTH+1 bits
- LANE_DEPTH, 4, words per lane FIFO; power of two, minimum 4
- clk  input  1  single clock, rising edge
- rst  input  1  reset; asynchronous assert, active-high
- start  input  1  one-cycle pulse; clears lanes/counters, latches `run_len`
- pause  input  1  freezes all state; gates `out_push`
- run_len  input  ADDR_WIDTH+1  words per lane per run; sampled on `start`, must be >= 1
- in_push  input  1  one word valid on every lane
- in_data  input  NUM_MEM x DATA_WIDTH  lane words, lane 0 at index 0
- in_full  output  1  back-pressure to producer
- out_full  input  1  downstream queue full
- out_push  output  1  merged word valid
- out_data  output  DATA_WIDTH  merged word
- run_done  output  1  one-cycle pulse after last word of a run is selected
- busy  output  1  state != IDLE
- overflow  output  1  sticky: push arrived while a lane was full

## Operation
- States: IDLE, MERGE, RUN_END. Reset -> IDLE. `start` from any state -> MERGE (sync clear of lanes, consumed counters, `overflow`; latch run_len). MERGE -> RUN_END when every lane's consumed count reaches run_len (including a selection this cycle). RUN_END -> MERGE after one cycle; `run_done` high during RUN_END. Only `start` or `rst` leave MERGE/RUN_END; IDLE ignores `in_push`.
- Lane i is exhausted when cons_cnt[i] == run_len. Selection in MERGE when !pause && !out_full: every non-exhausted lane must be non-empty, else stall (no pop, no push). Winner = minimum head among non-exhausted lanes, unsigned compare, ties to lowest index. Winner lane pops, cons_cnt increments.
- Lane FIFOs: push and pop of the same lane in one cycle leaves count unchanged. Push to a full lane drops that lane's word and sets `overflow`; other lanes still accept.
- `in_full` = any lane count >= LANE_DEPTH-2 (two-slot skid covers the producer's registered push plus memory read latency).
- cons_cnt is ADDR_WIDTH+1 bits; no wrap within a run; cleared on RUN_END.
- `pause` freezes FSM, lanes, counters, output register; `in_push` during pause is ignored.
- Reset values: out_push 0, out_data 0, run_done 0, busy 0, overflow 0, in_full 0, all lanes empty, counters 0.

## Timing
- Selection in cycle N -> `out_push`/`out_data` registered, valid in N+1. `out_push` = register && !pause.
- Latency from `in_push` to earliest `out_push`: 2 cycles (lane write N, select N+1, output N+2) when all lanes filled together.
- `run_done` asserts the cycle after the last selection, same cycle as the last `out_push`.
- Throughput: one word/cycle when no lane empties and `out_full` low.
- `out_full` sampled in selection cycle; the word already registered is still presented (downstream absorbs one in flight).
- `rst` mid-run: all state to reset values asynchronously; in-flight data discarded.

## Structure
- hams_pkg: `merge_state_e` enum {IDLE, MERGE, RUN_END}; `HAMS_MERGE_MIN_DEPTH = 4` constant.
- Sub-module `hams_merge_lane_fifo` (DEPTH, DATA_WIDTH; push, pop, head, count, full, empty), instantiated NUM_MEM times. Comparator tree and FSM in the top.

## Test plan
- Reset then start run_len=2, one push: lanes {5,1,7,3}, next {6,2,8,4} -> out 1,2,3,4,5,6,7,8; run_done with 8.
- Ties: run_len=1, all lanes 9 -> four pushes of 9 from lanes 0,1,2,3 in order.
- Stall: lane 2 delayed 3 cycles, run_len=2 -> no out_push while lane 2 non-exhausted and empty; final order still sorted.
- Back-pressure: out_full high 4 cycles mid-run -> no selection, no lost or duplicated word; pause 3 cycles -> out_push 0, resumes identically.
- in_full/overflow: LANE_DEPTH=4, out_full held, 2 pushes -> in_full=1; 3 further pushes -> overflow=1 stays until start.
- Reset mid-run at word 3 of 8 -> all outputs 0 next cycle; new start run_len=1 merges {4,3,2,1} -> 1,2,3,4.
